// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

  localparam int   DATA_BITS   = 7;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: tick marks the last clock of every bit period.
module baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With CLKS_PER_BIT=1 the count never leaves 0, so tick is constantly 1.
  assign tick = (cnt_q == CNT_LAST);

  // Count up, wrapping at the period end; clr parks the counter at 0.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/transmitter.sv
// Serial frame transmitter: start(0), 7 data bits LSB first, even parity, stop(1).
module transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 force_parity_err,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [2:0]           bit_q, bit_d;
  logic [SW-1:0]        stop_q, stop_d;
  logic                 so_q, so_d;
  logic                 tick, baud_clr, last_stop, accept;

  // Counter is held at 0 while idle so a fresh accept starts a full start bit.
  assign baud_clr = (state_q == ST_IDLE);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Final clock of the final stop period: the only in-frame accept window.
  assign last_stop = (state_q == ST_STOP) && tick && (stop_q == STOP_LAST);
  assign in_ready  = (state_q == ST_IDLE) || last_stop;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = last_stop;
  assign serial_out = so_q;

  // Frame sequencing; an accept (from IDLE or last stop clock) always restarts at START.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    if (accept) begin
      state_d = ST_START;
      shreg_d = data_in;
      par_d   = even_par(data_in) ^ force_parity_err;
      bit_d   = '0;
      stop_d  = '0;
    end else if (tick) begin
      case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
        ST_DATA: begin
          shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = ST_PARITY;
          else                   bit_d   = bit_q + 3'd1;
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          stop_d  = '0;
        end
        ST_STOP: begin
          if (stop_q == STOP_LAST) state_d = ST_IDLE;
          else                     stop_d  = stop_q + SW'(1);
        end
        default: ;
      endcase
    end
  end

  // Line level for the upcoming state, so serial_out is a clean flop output.
  always_comb begin
    case (state_d)
      ST_START:  so_d = START_LEVEL;
      ST_DATA:   so_d = shreg_d[0];
      ST_PARITY: so_d = par_d;
      default:   so_d = IDLE_LEVEL;
    endcase
  end

  // State registers; reset drops any frame and returns the line high at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      stop_q  <= '0;
      so_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      so_q    <= so_d;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: frame-level model (queue of expected line cycles) plus loopback decoder.
module tb_transmitter;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] in_valid = '0;
  logic [1:0] fpe = '0;
  logic [6:0] din0 = '0;
  logic [6:0] din1 = '0;
  logic [1:0] in_ready, so, busy, done;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Per instance: one entry per future clock = {last_clock_of_frame, line_level}.
  logic [1:0] mq [2][$];

  typedef struct {
    int         cyc;
    logic [6:0] data;
    logic       pok_n;
  } rx_t;
  rx_t        rxq[$];
  int         rx_cnt  = -1;
  logic       rx_prev = 1'b1;
  logic [7:0] rx_sh   = '0;

  always #5 clk = ~clk;

  transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(din0), .force_parity_err(fpe[0]), .serial_out(so[0]),
    .busy(busy[0]), .done(done[0]));

  transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(din1), .force_parity_err(fpe[1]), .serial_out(so[1]),
    .busy(busy[1]), .done(done[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expand one word into its per-clock line levels.
  task automatic push_frame(input int i, input logic [6:0] d, input logic f);
    int cpb, nb;
    logic [11:0] bits;
    cpb = (i == 0) ? 1 : 4;
    nb  = (i == 0) ? 10 : 11;
    bits = '1;
    bits[0]   = 1'b0;
    bits[7:1] = d;
    bits[8]   = (^d) ^ f;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < cpb; c++)
        mq[i].push_back({(b == nb - 1) && (c == cpb - 1), bits[b]});
  endtask

  // Reference model: ready when at most the current (last) clock remains queued.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit acc;
        acc = in_valid[i] && (mq[i].size() <= 1);
        if (mq[i].size() > 0) void'(mq[i].pop_front());
        if (acc) push_frame(i, (i == 0) ? din0 : din1, fpe[i]);
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] h;
      h = (mq[i].size() > 0) ? mq[i][0] : 2'b01;
      chk($sformatf("line%0d", i),  so[i],       h[0]);
      chk($sformatf("done%0d", i),  done[i],     h[1]);
      chk($sformatf("busy%0d", i),  busy[i],     mq[i].size() > 0);
      chk($sformatf("ready%0d", i), in_ready[i], mq[i].size() <= 1);
    end
  end

  // Loopback decoder on instance 0 (one bit per clock): start on high->low edge.
  always @(negedge clk) begin
    if (!rstn) begin
      rx_cnt  = -1;
      rx_prev = 1'b1;
    end else begin
      if (rx_cnt < 0) begin
        if (rx_prev && !so[0]) rx_cnt = 0;
      end else begin
        rx_sh[rx_cnt] = so[0];
        rx_cnt++;
        if (rx_cnt == 8) begin
          rxq.push_back('{cyc, rx_sh[6:0], ^rx_sh});
          rx_cnt = -1;
        end
      end
      rx_prev = so[0];
    end
  end

  task automatic wait_acc(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[i] && n < 200);
    if (!in_ready[i]) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_cap0(input logic [6:0] d, input logic f,
                           output logic [9:0] ln, output logic dn);
    din0 = d; fpe[0] = f; in_valid[0] = 1'b1;
    wait_acc(0);
    in_valid[0] = 1'b0; fpe[0] = 1'b0;
    ln = '0; dn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ln[k] = so[0];
      if (k == 9) dn = done[0];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] ln;
    logic       dn;
    logic [6:0] lbv [3];
    int rdy_hits, rdy_pos, busy_n;
    logic l4, l8, l32;
    lbv = '{7'h12, 7'h6B, 7'h40};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_line", so[0], 1);
      chk("idle_ready", in_ready[0], 1);
      chk("idle_busy", busy[0], 0);
    end
    @(posedge clk);
    #1;

    // Hand-computed frames, bit k = line level k clocks after accept.
    send_cap0(7'h55, 1'b0, ln, dn); chk("frame_55", ln, 10'b1010101010); chk("done_55", dn, 1);
    send_cap0(7'h7F, 1'b0, ln, dn); chk("frame_7f", ln, 10'b1111111110);
    send_cap0(7'h00, 1'b0, ln, dn); chk("frame_00", ln, 10'b1000000000);
    send_cap0(7'h01, 1'b0, ln, dn); chk("frame_01", ln, 10'b1100000010);
    rxq.delete();
    send_cap0(7'h01, 1'b1, ln, dn); chk("frame_01_err", ln, 10'b1000000010);
    chk("rx_err_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("rx_err_pok_n", rxq[0].pok_n, 1);

    // Back-to-back loopback with in_valid held high.
    rxq.delete();
    din0 = 7'h12; in_valid[0] = 1'b1;
    wait_acc(0);
    din0 = 7'h6B;
    wait_acc(0);
    din0 = 7'h40;
    wait_acc(0);
    in_valid[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("lb_count", rxq.size(), 3);
    for (int k = 0; k < rxq.size() && k < 3; k++) begin
      chk($sformatf("lb_data%0d", k), rxq[k].data, lbv[k]);
      chk($sformatf("lb_pok_n%0d", k), rxq[k].pok_n, 0);
      if (k > 0) chk($sformatf("lb_gap%0d", k), rxq[k].cyc - rxq[k-1].cyc, 10);
    end

    // Slow instance: 4 clocks per bit, 2 stop bits.
    din1 = 7'h2A; in_valid[1] = 1'b1;
    wait_acc(1);
    in_valid[1] = 1'b0;
    rdy_hits = 0; rdy_pos = 0; busy_n = 0; l4 = 1'b1; l8 = 1'b0; l32 = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (in_ready[1]) begin rdy_hits++; rdy_pos = k + 1; end
      if (busy[1]) busy_n++;
      if (k == 4)  l4  = so[1];
      if (k == 8)  l8  = so[1];
      if (k == 32) l32 = so[1];
    end
    @(negedge clk);
    chk("c4_busy_after", busy[1], 0);
    chk("c4_ready_hits", rdy_hits, 1);
    chk("c4_ready_pos", rdy_pos, 44);
    chk("c4_busy_len", busy_n, 44);
    chk("c4_d0", l4, 0);
    chk("c4_d1", l8, 1);
    chk("c4_parity", l32, 1);
    @(posedge clk);
    #1;

    // Reset during data bit 3 of 7'h33 (that bit is 0 on the line).
    din0 = 7'h33; in_valid[0] = 1'b1;
    wait_acc(0);
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_line", so[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    send_cap0(7'h33, 1'b0, ln, dn); chk("frame_33", ln, 10'b1001100110); chk("done_33", dn, 1);

    // Random traffic on both instances, with one asynchronous reset pulse.
    for (int n = 0; n < 800; n++) begin
      in_valid = 2'($urandom_range(0, 3));
      din0 = 7'($urandom);
      din1 = 7'($urandom);
      fpe[0] = ($urandom_range(0, 7) == 0);
      fpe[1] = ($urandom_range(0, 7) == 0);
      if (n == 400) begin
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = '0;
    repeat (50) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/transmitter.md
# transmitter

Serial frame transmitter that produces the single-wire format consumed by the team's serial `receiver`: idle-high line, one low start bit, 7 data bits LSB first, one even-parity bit, then at least one high stop bit. It accepts 7-bit words over a valid/ready handshake, serializes them at a configurable bit period, and supports back-to-back frames with the minimum legal idle gap. It sits on the transmit side of the link, between a producer (FIFO or controller) and the `serial_out` pin/wire.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. 1 matches the receiver, which samples every clock. Legal range is ≥1.
- `STOP_BITS`, default 1: high cycles (in bit periods) after parity before the next start bit. Legal range is ≥1.
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: producer has a word on `data_in`.
- `in_ready` out 1: transmitter accepts `data_in` on this edge if `in_valid`.
- `data_in` in 7: word to send; bit 0 transmitted first.
- `force_parity_err` in 1: sampled with `data_in` at accept; when 1, the transmitted parity bit is inverted (test aid).
- `serial_out` out 1: serial line, registered, idle 1.
- `busy` out 1: frame in progress (any state other than IDLE).
- `done` out 1: one-cycle pulse in the last clock of the last stop bit.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `serial_out`=1, `in_ready`=1. An accept (`in_valid && in_ready` at an edge) loads the shift register with `data_in`, latches parity = ^`data_in` XOR `force_parity_err`, clears the bit and baud counters, and enters START.
- **START:** `serial_out`=0 for one bit period, then enters DATA.
- **DATA:** `serial_out`=shreg[0]; the register shifts right at each bit-period end. Bit index 0..6 is held in a 3-bit counter. The state exits to PARITY after index 6.
- **PARITY:** `serial_out`=latched parity for one bit period. With even parity, the total count of ones in data plus parity is even, so the receiver reports `parity_ok_n`=0.
- **STOP:** `serial_out`=1 for `STOP_BITS` bit periods.
  - `in_ready`=1 only in the final clock of the final stop period.
  - An accept in that clock goes directly to START, giving back-to-back frames.
  - Otherwise the state enters IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. A bit period ends when the count reaches `CLKS_PER_BIT`-1, and the counter then wraps to 0. With `CLKS_PER_BIT`=1 every clock ends a bit period.
- `in_ready` is 0 in START/DATA/PARITY and in non-final STOP clocks. `data_in` is ignored there and not buffered.
- `in_ready` is combinational from state/counters only. It does not depend on `in_valid`.

## Timing
- **Reset values:** `serial_out`=1, `in_ready`=1 (IDLE), `busy`=0, `done`=0, all counters 0.
- **Reset mid-frame:** the line returns high immediately (async), the frame is dropped, and no `done` is issued.
- **Latency:** accept at edge T puts the start bit on `serial_out` from T+1 for `CLKS_PER_BIT` cycles.
- **Frame length:** (9+`STOP_BITS`)·`CLKS_PER_BIT` cycles. Back-to-back period is the same, so the next start bit immediately follows the last stop cycle.
- **Minimum gap:** the ≥1 high cycle between parity and the next start is mandatory; the receiver needs a high→low edge to detect a start.
- **`busy` and `done`:** `busy` rises the cycle after accept. It stays 1 across back-to-back frames and falls the cycle after the final stop when no new accept occurs. `done` fires once per frame, including when an accept coincides with it.
- **`in_valid` held low in the final STOP clock:** the state goes to IDLE, and a later accept still yields latency 1.

## Structure
- **Shared package `serial_pkg`:**
  - state enum (IDLE/START/DATA/PARITY/STOP)
  - `DATA_BITS`=7
  - `IDLE_LEVEL`=1'b1, `START_LEVEL`=1'b0
  - parity function `even_par(logic [6:0])`

  The receiver can reuse the same constants.
- **Sub-module `baud_tick`** (parameter `CLKS_PER_BIT`; ports `clk`, `rstn`, `clr`, `tick`): the bit-period counter. With `CLKS_PER_BIT`=1 it reduces to `tick`=1.

## Test plan
- **Reset and idle:** reset, idle 5 cycles → `serial_out`=1, `in_ready`=1, `busy`=0 throughout.
- **`data_in`=7'h55, `CLKS_PER_BIT`=1, `STOP_BITS`=1:** line reads 0,1,0,1,0,1,0,1, parity 0, stop 1 starting the cycle after accept. `done` pulses on the stop cycle.
- **Parity values:**
  - 7'h7F → parity bit 1.
  - 7'h00 → parity 0.
  - 7'h01 → parity 1.
  - 7'h01 with `force_parity_err`=1 → parity 0, and the looped-back receiver gives `parity_ok_n`=1.
- **Loopback, back-to-back:** `serial_out` drives `receiver.serial_in`; stream 7'h12, 7'h6B, 7'h40 with `in_valid` held high. The receiver gives `ready` pulses 10 cycles apart with `data_out` = 7'h12, 7'h6B, 7'h40, and `parity_ok_n`=0 each.
- **`CLKS_PER_BIT`=4, `STOP_BITS`=2, `data_in`=7'h2A:** each bit is held 4 cycles, the frame spans 44 cycles, and `in_ready` is high only in cycle 44.
- **Reset mid-frame:** assert `rstn`=0 during DATA bit 3 → `serial_out`=1 asynchronously, no `done`. After release, a new accept of 7'h33 transmits a correct full frame.
